// File: rtl/rf_pkg.sv
// Shared types and constants for the tag-renaming register file.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents:
//   RF_DATA_W / RF_TAG_W : default data and tag widths used by the instantiator
//   TAG_INVALID          : tag value meaning "register value is present"
//   rf_entry_t           : one register file entry {data, tag}
//   rf_wb_t              : one CDB write-back bundle {valid, tag, data}
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_TAG_W  = 4;

  localparam logic [RF_TAG_W-1:0] TAG_INVALID = '0;

  typedef struct packed {
    logic [RF_DATA_W-1:0] data;
    logic [RF_TAG_W-1:0]  tag;
  } rf_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [RF_TAG_W-1:0]  tag;
    logic [RF_DATA_W-1:0] data;
  } rf_wb_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: reg-0 zeroing, CDB bypass, output register with ce.
// Latency: 1 cycle from i_ce to o_entry.
// Backpressure: none; with i_ce low the output simply holds.
//
// Ports:
//   clk, rst  : clock, async active-low reset
//   i_ce      : capture enable
//   i_addr    : source register number (only used to detect reg 0)
//   i_entry   : array entry currently stored at i_addr
//   i_wb      : CDB write-back bundles, index 0 has highest priority
//   o_entry   : registered {data, tag}
module rf_read_port
  import rf_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int RW     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_ce,
  input  logic [RW-1:0]          i_addr,
  input  rf_entry_t              i_entry,
  input  rf_wb_t [NUM_WB-1:0]    i_wb,
  output rf_entry_t              o_entry
);

  rf_entry_t w_byp;
  rf_entry_t r_entry;

  always_comb begin
    w_byp = i_entry;
    if (i_addr == '0) begin
      w_byp = '0;
    end else if (i_entry.tag != TAG_INVALID) begin
      // Walk from the highest port down so the lowest matching port wins.
      for (int j = NUM_WB - 1; j >= 0; j--) begin
        if (i_wb[j].valid && (i_wb[j].tag == i_entry.tag)) begin
          w_byp.data = i_wb[j].data;
          w_byp.tag  = TAG_INVALID;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry <= '0;
    end else if (i_ce) begin
      r_entry <= w_byp;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/reg_file_multiport.sv
// Tag-renaming architectural register file: multi-port reads, dispatch tag install, CDB write-back.
// Latency: reads 1 cycle (registered, bypassed from same-cycle CDB); updates visible next cycle.
// Backpressure: none; every port is accepted every cycle, flush drops same-cycle dispatches.
//
// Ports:
//   clk, rst          : clock, async active-low reset
//   flush             : clear every pending tag, keep data, ignore dispatch this cycle
//   rd_ce/rd_addr     : read enable and source register per read port
//   rd_tag/rd_data    : registered read result per port
//   disp_we/addr/tag  : per dispatch slot tag allocation (higher slot wins on same reg)
//   wb_valid/tag/data : per CDB port result broadcast (lower port wins on same tag)
module reg_file_multiport
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = RF_DATA_W,
  parameter int TAG_W    = RF_TAG_W,
  parameter int NUM_RD   = 4,
  parameter int NUM_DISP = 2,
  parameter int NUM_WB   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_RD-1:0]          rd_ce,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]   rd_addr,
  output logic [NUM_RD*TAG_W-1:0]    rd_tag,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_DISP-1:0]        disp_we,
  input  logic [NUM_DISP*$clog2(NUM_REGS)-1:0] disp_addr,
  input  logic [NUM_DISP*TAG_W-1:0]  disp_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data
);

  localparam int RW = $clog2(NUM_REGS);

  rf_entry_t            r_regs [NUM_REGS];
  rf_entry_t            w_next [NUM_REGS];
  rf_wb_t [NUM_WB-1:0]  w_wb;

  for (genvar j = 0; j < NUM_WB; j++) begin : g_wb
    assign w_wb[j].valid = wb_valid[j];
    assign w_wb[j].tag   = wb_tag[j*TAG_W +: TAG_W];
    assign w_wb[j].data  = wb_data[j*DATA_W +: DATA_W];
  end

  // Next state per entry: CDB capture keyed on the old tag, then flush or
  // dispatch decides the new tag. Dispatch overriding the tag after a
  // capture is what lets a same-cycle re-rename keep the written data.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_next[r] = r_regs[r];
      if (r == 0) begin
        w_next[r] = '0;
      end else begin
        if (r_regs[r].tag != TAG_INVALID) begin
          for (int j = NUM_WB - 1; j >= 0; j--) begin
            if (w_wb[j].valid && (w_wb[j].tag == r_regs[r].tag)) begin
              w_next[r].data = w_wb[j].data;
              w_next[r].tag  = TAG_INVALID;
            end
          end
        end
        if (flush) begin
          w_next[r].tag = TAG_INVALID;
        end else begin
          // Ascending slot order so the youngest slot wins.
          for (int k = 0; k < NUM_DISP; k++) begin
            if (disp_we[k] && (disp_addr[k*RW +: RW] == RW'(r))) begin
              w_next[r].tag = disp_tag[k*TAG_W +: TAG_W];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= w_next[r];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_entry_t w_out;

    rf_read_port #(
      .NUM_WB (NUM_WB),
      .RW     (RW)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .i_ce    (rd_ce[p]),
      .i_addr  (rd_addr[p*RW +: RW]),
      .i_entry (r_regs[rd_addr[p*RW +: RW]]),
      .i_wb    (w_wb),
      .o_entry (w_out)
    );

    assign rd_tag[p*TAG_W +: TAG_W]    = w_out.tag;
    assign rd_data[p*DATA_W +: DATA_W] = w_out.data;
  end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Scoreboard bench for reg_file_multiport: directed scenarios then randomized traffic
// against an array-level reference model; expected read results are queued per port
// at issue time and popped by an independent monitor one cycle later.
module tb_reg_file_multiport;

  localparam int NR  = 32;
  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int NRD = 4;
  localparam int ND  = 2;
  localparam int NWB = 2;
  localparam int RW  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush;
  logic [NRD-1:0]    rd_ce;
  logic [NRD*RW-1:0] rd_addr;
  logic [NRD*TW-1:0] rd_tag;
  logic [NRD*DW-1:0] rd_data;
  logic [ND-1:0]     disp_we;
  logic [ND*RW-1:0]  disp_addr;
  logic [ND*TW-1:0]  disp_tag;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*TW-1:0] wb_tag;
  logic [NWB*DW-1:0] wb_data;

  reg_file_multiport #(
    .NUM_REGS (NR), .DATA_W (DW), .TAG_W (TW),
    .NUM_RD (NRD), .NUM_DISP (ND), .NUM_WB (NWB)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .rd_ce (rd_ce), .rd_addr (rd_addr), .rd_tag (rd_tag), .rd_data (rd_data),
    .disp_we (disp_we), .disp_addr (disp_addr), .disp_tag (disp_tag),
    .wb_valid (wb_valid), .wb_tag (wb_tag), .wb_data (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural value and pending tag per register.
  logic [DW-1:0] m_data [NR];
  logic [TW-1:0] m_tag  [NR];

  exp_t sb [NRD][$];
  exp_t last_exp [NRD];
  logic [NRD-1:0] vld_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] out_tag(input int p);
    return rd_tag[p*TW +: TW];
  endfunction

  function automatic logic [DW-1:0] out_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_data[r] = '0;
      m_tag[r]  = '0;
    end
    for (int p = 0; p < NRD; p++) begin
      sb[p].delete();
      last_exp[p].tag  = '0;
      last_exp[p].data = '0;
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; rd_ce = '0; rd_addr = '0;
    disp_we = '0; disp_addr = '0; disp_tag = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_ce[p] = 1'b1;
    rd_addr[p*RW +: RW] = RW'(a);
  endtask

  task automatic set_disp(input int k, input int a, input int t);
    disp_we[k] = 1'b1;
    disp_addr[k*RW +: RW] = RW'(a);
    disp_tag[k*TW +: TW] = TW'(t);
  endtask

  task automatic set_wb(input int j, input int t, input logic [DW-1:0] d);
    wb_valid[j] = 1'b1;
    wb_tag[j*TW +: TW] = TW'(t);
    wb_data[j*DW +: DW] = d;
  endtask

  // Which CDB port (if any) delivers the result for tag t this cycle; -1 if none.
  function automatic int cdb_hit(input logic [TW-1:0] t);
    if (t == 0) return -1;
    for (int j = 0; j < NWB; j++)
      if (wb_valid[j] && wb_tag[j*TW +: TW] == t) return j;
    return -1;
  endfunction

  // Called at a negedge with inputs driven: queue read expectations from the
  // pre-edge architectural state, advance the model, wait for the next negedge.
  task automatic tick();
    logic [DW-1:0] nd [NR];
    logic [TW-1:0] nt [NR];
    for (int p = 0; p < NRD; p++) begin
      if (rd_ce[p]) begin
        int a;
        int h;
        exp_t e;
        a = int'(rd_addr[p*RW +: RW]);
        e.tag = m_tag[a];
        e.data = m_data[a];
        h = cdb_hit(m_tag[a]);
        if (a == 0) begin
          e.tag = '0; e.data = '0;
        end else if (h >= 0) begin
          e.tag = '0; e.data = wb_data[h*DW +: DW];
        end
        sb[p].push_back(e);
      end
    end
    for (int r = 0; r < NR; r++) begin
      int h;
      nd[r] = m_data[r];
      nt[r] = m_tag[r];
      h = cdb_hit(m_tag[r]);
      if (r != 0 && h >= 0) begin
        nd[r] = wb_data[h*DW +: DW];
        nt[r] = '0;
      end
      if (flush) nt[r] = '0;
    end
    if (!flush) begin
      for (int k = 0; k < ND; k++) begin
        int a;
        a = int'(disp_addr[k*RW +: RW]);
        if (disp_we[k] && a != 0) nt[a] = disp_tag[k*TW +: TW];
      end
    end
    for (int r = 0; r < NR; r++) begin
      m_data[r] = nd[r];
      m_tag[r]  = nt[r];
    end
    @(negedge clk);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= rd_ce;
  end

  // Monitor: a read issued last cycle is now on the port; otherwise it must hold.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NRD; p++) begin
        if (vld_q[p]) begin
          if (sb[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: port %0d got a result with nothing expected", p);
          end else begin
            exp_t e;
            e = sb[p].pop_front();
            chk($sformatf("rd%0d_tag", p), 32'(out_tag(p)), 32'(e.tag));
            chk($sformatf("rd%0d_data", p), out_data(p), e.data);
            last_exp[p] = e;
          end
        end else begin
          chk($sformatf("rd%0d_hold_tag", p), 32'(out_tag(p)), 32'(last_exp[p].tag));
          chk($sformatf("rd%0d_hold_data", p), out_data(p), last_exp[p].data);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int p = 0; p < NRD; p++) begin
      chk("reset_tag", 32'(out_tag(p)), 32'h0);
      chk("reset_data", out_data(p), 32'h0);
    end
    rst = 1'b1;

    // Read after reset.
    set_rd(0, 5); tick();
    chk("t1_tag", 32'(out_tag(0)), 32'h0);
    chk("t1_data", out_data(0), 32'h0);

    // Dispatch, read pending tag, write back, read value.
    clear_inputs(); set_disp(0, 3, 7); tick();
    clear_inputs(); set_rd(0, 3); tick();
    chk("t2_pending_tag", 32'(out_tag(0)), 32'h7);
    clear_inputs(); set_wb(0, 7, 32'hDEAD); tick();
    clear_inputs(); set_rd(1, 3); tick();
    chk("t2_wb_tag", 32'(out_tag(1)), 32'h0);
    chk("t2_wb_data", out_data(1), 32'hDEAD);

    // Same-cycle CDB bypass on read.
    clear_inputs(); set_disp(0, 4, 2); tick();
    clear_inputs(); set_rd(2, 4); set_wb(1, 2, 32'h55); tick();
    chk("t3_byp_tag", 32'(out_tag(2)), 32'h0);
    chk("t3_byp_data", out_data(2), 32'h55);

    // Write-back and re-dispatch of the same register in one cycle.
    clear_inputs(); set_disp(1, 6, 3); tick();
    clear_inputs(); set_wb(0, 3, 32'h11); set_disp(0, 6, 9); tick();
    clear_inputs(); set_rd(3, 6); tick();
    chk("t4_tag", 32'(out_tag(3)), 32'h9);
    chk("t4_data", out_data(3), 32'h11);

    // Both slots target r8; youngest wins; stale write-back ignored.
    clear_inputs(); set_disp(0, 8, 4); set_disp(1, 8, 5); tick();
    clear_inputs(); set_wb(0, 4, 32'h99); tick();
    clear_inputs(); set_rd(0, 8); tick();
    chk("t5_tag", 32'(out_tag(0)), 32'h5);
    chk("t5_data", out_data(0), 32'h0);

    // Flush with a matching write-back and a dropped dispatch.
    clear_inputs(); set_disp(0, 1, 10); set_disp(1, 2, 11); tick();
    clear_inputs(); flush = 1'b1; set_wb(0, 10, 32'h77); set_disp(0, 9, 12); set_rd(0, 1); tick();
    chk("t6_flush_rd_tag", 32'(out_tag(0)), 32'h0);
    chk("t6_flush_rd_data", out_data(0), 32'h77);
    clear_inputs(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 9); tick();
    chk("t6_r1_data", out_data(0), 32'h77);
    chk("t6_r2_tag", 32'(out_tag(1)), 32'h0);
    chk("t6_r9_tag", 32'(out_tag(2)), 32'h0);

    // Register 0 ignores dispatch and write-back.
    clear_inputs(); set_disp(0, 0, 6); tick();
    clear_inputs(); set_wb(0, 6, 32'hAB); set_rd(3, 0); tick();
    clear_inputs(); set_rd(3, 0); tick();
    chk("r0_tag", 32'(out_tag(3)), 32'h0);
    chk("r0_data", out_data(3), 32'h0);

    // Randomized traffic with an async reset in the middle.
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(0, 1) == 1) set_rd(p, $urandom_range(0, NR - 1));
      for (int k = 0; k < ND; k++)
        if ($urandom_range(0, 2) == 0) set_disp(k, $urandom_range(0, NR - 1), $urandom_range(1, 15));
      for (int j = 0; j < NWB; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          int t;
          t = int'(m_tag[$urandom_range(1, NR - 1)]);
          if (t == 0 || $urandom_range(0, 4) == 0) t = $urandom_range(1, 15);
          set_wb(j, t, $urandom);
        end
      end
      if ($urandom_range(0, 24) == 0) flush = 1'b1;
      if (c == 300) begin
        #2 rst = 1'b0;
        #1;
        for (int p = 0; p < NRD; p++) begin
          chk("midrst_tag", 32'(out_tag(p)), 32'h0);
          chk("midrst_data", out_data(p), 32'h0);
        end
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    clear_inputs();
    @(negedge clk);
    for (int p = 0; p < NRD; p++)
      chk("sb_drained", 32'(sb[p].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
